// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: expands forward to round 10, then emits round keys 10..0.
// Optional build macro AES_EQINV_KEY_EN: rounds 1..9 are output through InvMixColumns (equivalent inverse cipher).
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Multiplicative inverse as a^254 (maps 0 to 0), followed by the affine transform.
  always_comb begin
    sq  = a_i;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_inv_key_schedule (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state_o
);
  // Handshake: a key transfers on any rising edge where key_valid && key_ready;
  // while key_valid=1 and key_ready=0, key_out and round_idx are held.
  typedef enum logic [1:0] {S_IDLE, S_FWD, S_EMIT} state_t;

  state_t       state_q, state_d;
  logic [127:0] w_q, w_d;
  logic [3:0]   r_q, r_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3, w3_inv;
  logic [31:0]  sbox_in, rot, sub, rcon_word;
  logic [3:0]   rcon_idx;
  logic [127:0] fwd_next, inv_next;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign w0 = w_q[127:96];
  assign w1 = w_q[95:64];
  assign w2 = w_q[63:32];
  assign w3 = w_q[31:0];
  assign w3_inv = w3 ^ w2;

  // Shared S-box bank: forward step substitutes old w3, inverse step the recovered w3.
  assign sbox_in   = (state_q == S_EMIT) ? w3_inv : w3;
  assign rot       = {sbox_in[23:0], sbox_in[31:24]};
  assign rcon_idx  = (state_q == S_EMIT) ? r_q : r_q + 4'd1;
  assign rcon_word = {rcon(rcon_idx), 24'h000000};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a_i(rot[8*g +: 8]), .y_o(sub[8*g +: 8]));
  end

  always_comb begin
    logic [31:0] f0, f1, f2, f3;
    f0 = w0 ^ sub ^ rcon_word;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;
    fwd_next = {f0, f1, f2, f3};
    inv_next = {w0 ^ sub ^ rcon_word, w1 ^ w0, w2 ^ w1, w3_inv};
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d     = key_in;
          r_d     = 4'd0;
          state_d = S_FWD;
        end
      end
      S_FWD: begin
        w_d = fwd_next;
        r_d = r_q + 4'd1;
        if (r_q == 4'd9) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (key_ready) begin
          if (r_q != 4'd0) begin
            w_d = inv_next;
            r_d = r_q - 4'd1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

`ifdef AES_EQINV_KEY_EN
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Only the presented key is transformed; the stored schedule stays raw.
  always_comb begin
    key_out = '0;
    if (state_q == S_EMIT) begin
      if (r_q != 4'd0 && r_q != 4'd10)
        key_out = {inv_mix_col(w0), inv_mix_col(w1), inv_mix_col(w2), inv_mix_col(w3)};
      else
        key_out = w_q;
    end
  end
`else
  assign key_out = (state_q == S_EMIT) ? w_q : '0;
`endif

  assign key_valid   = (state_q == S_EMIT);
  assign round_idx   = (state_q == S_EMIT) ? r_q : 4'd0;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign dbg_state_o = state_q;
endmodule
